// File: rtl/tune_loader_if.sv
// tune_loader_if: SPI pins, tune parameter outputs and player handshake of tune_loader.
// The loader uses the slave modport; the microcontroller/player side uses master.
interface tune_loader_if;
  logic        sck;
  logic        sdi;
  logic        cs_n;
  logic        makingMusic;
  logic [31:0] freq0;
  logic [31:0] freq1;
  logic [31:0] freq2;
  logic [31:0] freq3;
  logic [31:0] dur0;
  logic [31:0] dur1;
  logic [31:0] dur2;
  logic [31:0] dur3;
  logic [7:0]  repThreshold;
  logic        start;
  logic        frame_err;

  modport slave (
    input  sck, sdi, cs_n, makingMusic,
    output freq0, freq1, freq2, freq3, dur0, dur1, dur2, dur3,
    output repThreshold, start, frame_err
  );

  modport master (
    output sck, sdi, cs_n, makingMusic,
    input  freq0, freq1, freq2, freq3, dur0, dur1, dur2, dur3,
    input  repThreshold, start, frame_err
  );
endinterface

// File: rtl/tune_loader.sv
// tune_loader: mode-0 SPI receiver that loads tune parameters and requests playback.
// Defining TUNE_LOADER_CHECKSUM_EN adds an 8-bit XOR trailer check (272-bit frames).
module tune_loader #(
  parameter int SYNC_STAGES = 2
) (
  input logic          clk,
  input logic          reset_n,
  tune_loader_if.slave bus
);
`ifdef TUNE_LOADER_CHECKSUM_EN
  localparam int FRAME_BITS = 272;
`else
  localparam int FRAME_BITS = 264;
`endif
  localparam int TUNE_BITS = 264;

  typedef enum logic [1:0] {IDLE, RECV, PENDING, START} state_t;
  state_t r_state, w_next;

  logic [SYNC_STAGES-1:0] r_sckSync, r_sdiSync, r_csSync;
  logic                   r_sckPrev, r_csPrev;
  logic                   w_sck, w_sdi, w_cs;
  logic                   w_sckRise, w_csRise, w_csFall;
  logic                   r_rxBusy;
  logic [8:0]             r_count;
  logic [FRAME_BITS-1:0]  r_shift;
  logic [TUNE_BITS-1:0]   r_shadow, r_tune, w_payload;
  logic                   r_queued, r_start, r_frameErr;
  logic                   w_sumOk, w_frameDone, w_frameBad, w_commit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sckSync <= '0;
      r_sdiSync <= '0;
      r_csSync  <= '1;
      r_sckPrev <= 1'b0;
      r_csPrev  <= 1'b1;
    end else begin
      r_sckSync <= {r_sckSync[SYNC_STAGES-2:0], bus.sck};
      r_sdiSync <= {r_sdiSync[SYNC_STAGES-2:0], bus.sdi};
      r_csSync  <= {r_csSync[SYNC_STAGES-2:0], bus.cs_n};
      r_sckPrev <= w_sck;
      r_csPrev  <= w_cs;
    end
  end

  assign w_sck     = r_sckSync[SYNC_STAGES-1];
  assign w_sdi     = r_sdiSync[SYNC_STAGES-1];
  assign w_cs      = r_csSync[SYNC_STAGES-1];
  assign w_sckRise = w_sck & ~r_sckPrev;
  assign w_csRise  = w_cs & ~r_csPrev;
  assign w_csFall  = ~w_cs & r_csPrev;

`ifdef TUNE_LOADER_CHECKSUM_EN
  logic [7:0] w_xor;
  always_comb begin
    w_xor = '0;
    for (int i = 1; i <= TUNE_BITS / 8; i++) begin
      w_xor = w_xor ^ r_shift[i*8 +: 8];
    end
    w_sumOk = (w_xor == r_shift[7:0]);
  end
  assign w_payload = r_shift[FRAME_BITS-1 -: TUNE_BITS];
`else
  assign w_sumOk   = 1'b1;
  assign w_payload = r_shift;
`endif

  assign w_frameDone = r_rxBusy & w_csRise & (r_count == 9'(FRAME_BITS)) & w_sumOk;
  assign w_frameBad  = r_rxBusy & w_csRise & ~((r_count == 9'(FRAME_BITS)) & w_sumOk);
  assign w_commit    = (r_state == PENDING) & ~bus.makingMusic;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // After the handshake, a queued frame re-arms PENDING and an unfinished one resumes in RECV.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_csFall) w_next = RECV;
      RECV: begin
        if (w_frameDone)     w_next = PENDING;
        else if (w_frameBad) w_next = IDLE;
      end
      PENDING: if (!bus.makingMusic) w_next = START;
      START: begin
        if (bus.makingMusic) begin
          if (r_queued || w_frameDone)      w_next = PENDING;
          else if (r_rxBusy && !w_csRise)   w_next = RECV;
          else                              w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rxBusy   <= 1'b0;
      r_count    <= '0;
      r_shift    <= '0;
      r_shadow   <= '0;
      r_tune     <= '0;
      r_queued   <= 1'b0;
      r_start    <= 1'b0;
      r_frameErr <= 1'b0;
    end else begin
      if (w_csFall) begin
        r_rxBusy <= 1'b1;
        r_count  <= '0;
      end else begin
        if (r_rxBusy && w_sckRise) begin
          r_shift <= {r_shift[FRAME_BITS-2:0], w_sdi};
          if (r_count != 9'd511) r_count <= r_count + 9'd1;
        end
        if (w_csRise) r_rxBusy <= 1'b0;
      end
      // The shadow always takes the newest frame; a commit in the same cycle uses the old one.
      if (w_frameDone) r_shadow <= w_payload;
      if (r_state == START && bus.makingMusic)
        r_queued <= 1'b0;
      else if (w_frameDone && (r_state == START || w_commit))
        r_queued <= 1'b1;
      if (w_commit) r_tune <= r_shadow;
      r_start    <= (w_next == START);
      r_frameErr <= w_frameBad;
    end
  end

  assign bus.freq0        = r_tune[263:232];
  assign bus.freq1        = r_tune[231:200];
  assign bus.freq2        = r_tune[199:168];
  assign bus.freq3        = r_tune[167:136];
  assign bus.dur0         = r_tune[135:104];
  assign bus.dur1         = r_tune[103:72];
  assign bus.dur2         = r_tune[71:40];
  assign bus.dur3         = r_tune[39:8];
  assign bus.repThreshold = r_tune[7:0];
  assign bus.start        = r_start;
  assign bus.frame_err    = r_frameErr;
endmodule

// File: doc/tune_loader.md
# tune_loader

Serial front end that receives a complete tune description from the microcontroller over a mode-0 SPI link and drives the parameter and start inputs of the `tune` player. It sits directly upstream of `tune`: it presents freq0..3, dur0..3 and repThreshold as stable registers and raises start. It never changes those registers while `tune` reports makingMusic.

## Interface
- SYNC_STAGES, 2: flip-flop depth of the synchronizers on sck, sdi and cs_n (minimum 2).
- clk  input  1  system clock; sole clock domain.
- reset_n  input  1  asynchronous, active-low reset.
- sck  input  1  SPI clock from the MCU; asynchronous to clk; idles low.
- sdi  input  1  SPI data, MSB first; sampled on sck rising edge.
- cs_n  input  1  active-low frame select; one frame per low period.
- makingMusic  input  1  busy flag from `tune`.
- freq0..freq3  output  32 each  note frequency words.
- dur0..dur3  output  32 each  note duration words.
- repThreshold  output  8  repeat count.
- start  output  1  play request to `tune`.
- frame_err  output  1  one-cycle pulse when a frame is rejected.

## Operation
- Frame is 264 bits, MSB first, in this field order: freq0, freq1, freq2, freq3, dur0, dur1, dur2, dur3, repThreshold.
- sck, sdi and cs_n pass through SYNC_STAGES flops.
- Edges are detected on the synchronized sck and cs_n.
- State machine:
  - IDLE: synchronized cs_n falling edge clears the 9-bit bit counter and goes to RECV.
  - RECV: each sck rising edge shifts sdi into a 264-bit shift register and increments the counter. The counter saturates at 511.
  - RECV on cs_n rising edge:
    - If count == 264, copy the shift register to the shadow register and go to PENDING.
    - Otherwise pulse frame_err and go to IDLE. Output registers are untouched.
  - PENDING: while makingMusic = 1, wait. When makingMusic = 0, copy shadow to the output registers and go to START.
  - START: start = 1. When makingMusic = 1 is sampled, go to IDLE; start drops on that transition.
- A new cs_n falling edge in PENDING or START starts reception into the shift register without leaving the state.
  - A valid completion then overwrites the shadow register. The latest frame wins, and only one tune is queued.
  - A completion in START also re-arms PENDING after the handshake.
- Output registers change only on the PENDING to START transition.
- Reset (reset_n low, any time, including mid-frame):
  - all outputs go to 0; shift, shadow and counter registers clear; state goes to IDLE.
  - A partially clocked frame is lost. The first cs_n falling edge after reset release starts a fresh frame.

## Timing
- sck high and low times must each be at least SYNC_STAGES+2 clk periods.
- cs_n must stay high at least SYNC_STAGES+2 clk periods between frames.
- Bit capture: a sck rising edge at the pin is shifted in SYNC_STAGES+1 cycles later.
- cs_n rising edge at the pin to state change: SYNC_STAGES+1 cycles.
- Commit with makingMusic = 0:
  - The output registers load on the first clk edge after entering PENDING.
  - start rises on the same edge as the output registers load.
  - start is registered, so the outputs and start become visible together.
- start stays high until the cycle after makingMusic is sampled high. There is no timeout.
- frame_err is high for exactly 1 cycle, starting 1 cycle after the rejecting cs_n edge is detected.
- Simultaneous makingMusic fall and new frame completion in PENDING: commit the older shadow this cycle. The new frame moves into the shadow and is queued.

## Configuration
- TUNE_LOADER_CHECKSUM_EN:
  - Defined:
    - The frame is 272 bits; the 8-bit trailer is the XOR of the 33 preceding bytes.
    - A trailer mismatch, or a count other than 272, pulses frame_err and discards the frame.
    - The shift register widens to 272 bits.
  - Undefined: frame is 264 bits with no trailer, and no checksum logic is built.

## Test plan
- Reset then one valid frame, with makingMusic = 0 (freq 3,5,1,2; dur 20,15,6,15; rep 2):
  - Outputs show those values and start rises on the same cycle.
  - start holds until makingMusic is driven high, then drops 1 cycle later.
- Short frame of 263 bits: frame_err pulses for 1 cycle; outputs stay 0; start stays 0.
- Frame completes while makingMusic = 1 (outputs already holding the earlier tune):
  - Outputs are unchanged until makingMusic falls, then update with start.
- Two valid frames (A with freq0 = 3, then B with freq0 = 7) arrive while makingMusic = 1:
  - Only B is committed, and exactly one start occurs after makingMusic falls.
- reset_n pulsed low after 100 bits of a frame:
  - All outputs read 0 immediately, with no start.
  - A following full frame is received correctly.
- With TUNE_LOADER_CHECKSUM_EN defined:
  - A correct trailer commits.
  - Trailer XOR 0x01 pulses frame_err with no commit.
